// File: rtl/sipo_deserializer_if.sv
// Parallel-side and serial-side signal bundle for the SIPO deserializer.
// The master modport is the environment (serial producer plus word consumer);
// the slave modport is the deserializer itself.
interface sipo_deserializer_if #(
    parameter int N = 4
) ();
    localparam int CW = $clog2(N);

    // Serial receive side
    logic          serial_in;
    logic          shift_en;
    logic          frame_start;

    // Parallel word side
    logic [N-1:0]  data_out;
    logic          data_valid;
    logic          data_ready;

    // Status
    logic          overrun;
    logic          clr_overrun;
    logic [CW-1:0] bit_cnt;

    modport master (
        output serial_in,
        output shift_en,
        output frame_start,
        output data_ready,
        output clr_overrun,
        input  data_out,
        input  data_valid,
        input  overrun,
        input  bit_cnt
    );

    modport slave (
        input  serial_in,
        input  shift_en,
        input  frame_start,
        input  data_ready,
        input  clr_overrun,
        output data_out,
        output data_valid,
        output overrun,
        output bit_cnt
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receive stage. Collects one bit per shift_en strobe,
// aligns words on frame_start, and hands completed N-bit words to a
// registered valid/ready output stage. A word that completes while the
// output still holds an unaccepted word is dropped and flagged as overrun.
module sipo_deserializer #(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sipo_deserializer_if.slave    bus
);
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] ZERO_CNT  = CW'(0);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);
    localparam logic [N-1:0]  ZERO_WORD = {N{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Shift one received bit into a partial word. With LSB_FIRST the bit
    // enters at the top and walks down, so the first bit of a word ends up
    // in bit 0 after N shifts; otherwise it enters at the bottom and the
    // first bit ends up in bit N-1.
    function automatic logic [N-1:0] shift_bit(input logic [N-1:0] cur,
                                               input logic         bit_in);
        logic [N-1:0] nxt;
        if (LSB_FIRST) begin
            nxt = {bit_in, cur[N-1:1]};
        end else begin
            nxt = {cur[N-2:0], bit_in};
        end
        return nxt;
    endfunction

    // Registered state
    state_t        state_r;
    logic [N-1:0]  sr_r;
    logic [CW-1:0] bit_cnt_r;
    logic [N-1:0]  data_out_r;
    logic          data_valid_r;
    logic          overrun_r;

    // Next-state values
    state_t        state_s;
    logic [N-1:0]  sr_s;
    logic [CW-1:0] bit_cnt_s;
    logic          complete_s;
    logic [N-1:0]  data_out_s;
    logic          data_valid_s;
    logic          overrun_s;
    logic          accept_s;
    logic          drop_s;

    // Framing FSM: alignment, bit capture, resync and word completion.
    always_comb begin
        state_s    = state_r;
        sr_s       = sr_r;
        bit_cnt_s  = bit_cnt_r;
        complete_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Bits before the first frame_start carry no alignment and
                // are ignored.
                if (bus.shift_en && bus.frame_start) begin
                    sr_s      = shift_bit(ZERO_WORD, bus.serial_in);
                    bit_cnt_s = ONE_CNT;
                    state_s   = ST_COLLECT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end

            ST_COLLECT: begin
                if (bus.shift_en) begin
                    if (bus.frame_start && (bit_cnt_r != ZERO_CNT)) begin
                        // Resync: the partial word is abandoned silently and
                        // this bit starts a new word.
                        sr_s      = shift_bit(ZERO_WORD, bus.serial_in);
                        bit_cnt_s = ONE_CNT;
                    end else if (bit_cnt_r == LAST_CNT) begin
                        // Last bit of the word: hand it on and keep
                        // collecting so back-to-back words stay aligned.
                        sr_s       = shift_bit(sr_r, bus.serial_in);
                        bit_cnt_s  = ZERO_CNT;
                        complete_s = 1'b1;
                    end else begin
                        sr_s      = shift_bit(sr_r, bus.serial_in);
                        bit_cnt_s = bit_cnt_r + ONE_CNT;
                    end
                end else begin
                    // Gap in the strobe: hold the partial word.
                    sr_s      = sr_r;
                    bit_cnt_s = bit_cnt_r;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                sr_s      = ZERO_WORD;
                bit_cnt_s = ZERO_CNT;
            end
        endcase
    end

    // Output stage: load on completion when there is room (including room
    // freed by an accept on the same edge), otherwise drop and flag overrun.
    always_comb begin
        accept_s     = data_valid_r & bus.data_ready;
        data_out_s   = data_out_r;
        data_valid_s = data_valid_r;
        drop_s       = 1'b0;

        if (complete_s) begin
            if (!data_valid_r || accept_s) begin
                data_out_s   = sr_s;
                data_valid_s = 1'b1;
            end else begin
                drop_s       = 1'b1;
            end
        end else if (accept_s) begin
            // data_out keeps the accepted word; only valid drops.
            data_valid_s = 1'b0;
        end else begin
            data_valid_s = data_valid_r;
        end

        // A new drop wins over a clear in the same cycle.
        if (drop_s) begin
            overrun_s = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sr_r         <= ZERO_WORD;
            bit_cnt_r    <= ZERO_CNT;
            data_out_r   <= ZERO_WORD;
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            sr_r         <= sr_s;
            bit_cnt_r    <= bit_cnt_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            overrun_r    <= overrun_s;
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.bit_cnt    = bit_cnt_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. Two instances (LSB-first and
// MSB-first) see the same serial stream; each has its own queue of expected
// words, popped by a monitor whenever a word is handed over (valid & ready).
module tb_sipo_deserializer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic serial_in, shift_en, frame_start, data_ready, clr_overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [N-1:0] q_a[$];
    logic [N-1:0] q_b[$];
    int           acc_cyc_a[$];

    sipo_deserializer_if #(.N(N)) bus_a ();
    sipo_deserializer_if #(.N(N)) bus_b ();

    assign bus_a.serial_in   = serial_in;
    assign bus_a.shift_en    = shift_en;
    assign bus_a.frame_start = frame_start;
    assign bus_a.data_ready  = data_ready;
    assign bus_a.clr_overrun = clr_overrun;
    assign bus_b.serial_in   = serial_in;
    assign bus_b.shift_en    = shift_en;
    assign bus_b.frame_start = frame_start;
    assign bus_b.data_ready  = data_ready;
    assign bus_b.clr_overrun = clr_overrun;

    sipo_deserializer #(.N(N), .LSB_FIRST(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sipo_deserializer #(.N(N), .LSB_FIRST(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare every handed-over word with the queue.
    always @(negedge clk) begin
        if (!rst && bus_a.data_valid && data_ready) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a: unexpected word %0h, expected none", bus_a.data_out);
            end else begin
                check("mon_a_word", 32'(bus_a.data_out), 32'(q_a.pop_front()));
            end
            acc_cyc_a.push_back(cyc);
        end
        if (!rst && bus_b.data_valid && data_ready) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_b: unexpected word %0h, expected none", bus_b.data_out);
            end else begin
                check("mon_b_word", 32'(bus_b.data_out), 32'(q_b.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        shift_en    = 1'b1;
        frame_start = fs;
        tick();
        shift_en    = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    // bits[0] is sent first
    task automatic send_word(input logic [N-1:0] bits, input logic fs);
        for (int i = 0; i < N; i++) begin
            send_bit(bits[i], fs && (i == 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] w;
        rst = 1'b1;
        serial_in = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
        data_ready = 1'b0; clr_overrun = 1'b0;
        tick(); tick();
        check("rst_dout_a",  32'(bus_a.data_out),   32'h0);
        check("rst_valid_a", 32'(bus_a.data_valid), 32'h0);
        check("rst_ovr_a",   32'(bus_a.overrun),    32'h0);
        check("rst_cnt_a",   32'(bus_a.bit_cnt),    32'h0);
        check("rst_valid_b", 32'(bus_b.data_valid), 32'h0);
        rst = 1'b0;

        // 1: bits 1,1,0,1 -> A: 4'hB, B: 4'hD
        data_ready = 1'b1;
        q_a.push_back(4'hB); q_b.push_back(4'hD);
        send_word(4'b1011, 1'b1);
        check("t1_valid",    32'(bus_a.data_valid), 32'h1);
        check("t1_dout_b",   32'(bus_b.data_out),   32'hD);
        check("t1_cnt_wrap", 32'(bus_a.bit_cnt),    32'h0);
        tick();
        check("t1_valid_one_cycle", 32'(bus_a.data_valid), 32'h0);
        // mid-word reset
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        check("t1_cnt_partial", 32'(bus_a.bit_cnt), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t1_rst_dout",  32'(bus_a.data_out),   32'h0);
        check("t1_rst_valid", 32'(bus_a.data_valid), 32'h0);
        check("t1_rst_cnt",   32'(bus_a.bit_cnt),    32'h0);
        check("t1_rst_ovr",   32'(bus_a.overrun),    32'h0);
        // IDLE ignores bits without frame_start
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t1_idle_ignore", 32'(bus_a.bit_cnt), 32'h0);

        // 2: 4'hB with growing gaps between bits
        q_a.push_back(4'hB); q_b.push_back(4'hD);
        w = 4'hB;
        for (int i = 0; i < N; i++) begin
            send_bit(w[i], i == 0);
            if (i < N - 1) begin
                for (int g = 0; g <= i; g++) begin
                    tick();
                    check("t2_cnt_hold", 32'(bus_a.bit_cnt), 32'(i + 1));
                end
            end
        end
        check("t2_valid", 32'(bus_a.data_valid), 32'h1);
        tick();

        // 3: output blocked -> second word dropped, overrun
        data_ready = 1'b0;
        send_word(4'hA, 1'b1);
        check("t3_dout_a1", 32'(bus_a.data_out), 32'hA);
        check("t3_dout_b1", 32'(bus_b.data_out), 32'h5);
        check("t3_ovr_pre", 32'(bus_a.overrun),  32'h0);
        send_word(4'h5, 1'b0);
        check("t3_dout_hold_a", 32'(bus_a.data_out),   32'hA);
        check("t3_dout_hold_b", 32'(bus_b.data_out),   32'h5);
        check("t3_ovr_a",       32'(bus_a.overrun),    32'h1);
        check("t3_ovr_b",       32'(bus_b.overrun),    32'h1);
        check("t3_valid",       32'(bus_a.data_valid), 32'h1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t3_ovr_clr", 32'(bus_a.overrun), 32'h0);
        q_a.push_back(4'hA); q_b.push_back(4'h5);
        data_ready = 1'b1;
        tick();
        check("t3_valid_drop", 32'(bus_a.data_valid), 32'h0);

        // 4: continuous stream 3, C with one frame_start
        acc_cyc_a.delete();
        q_a.push_back(4'h3); q_a.push_back(4'hC);
        q_b.push_back(4'hC); q_b.push_back(4'h3);
        send_word(4'h3, 1'b1);
        send_word(4'hC, 1'b0);
        tick(); tick();
        check("t4_pulses", 32'(acc_cyc_a.size()), 32'h2);
        if (acc_cyc_a.size() == 2) begin
            check("t4_spacing", 32'(acc_cyc_a[1] - acc_cyc_a[0]), 32'h4);
        end
        check("t4_ovr", 32'(bus_a.overrun), 32'h0);

        // 5: partial 1,0 then resync with 4'h6
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        q_a.push_back(4'h6); q_b.push_back(4'h6);
        send_bit(1'b0, 1'b1);
        check("t5_resync_cnt", 32'(bus_a.bit_cnt), 32'h1);
        send_bit(1'b1, 1'b0);
        check("t5_no_partial_word", 32'(bus_a.data_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t5_valid", 32'(bus_a.data_valid), 32'h1);
        check("t5_ovr",   32'(bus_a.overrun),    32'h0);
        tick();

        // 6: bits 1,0,1,1 -> B: 4'hB (MSB first); completion with accept
        data_ready = 1'b0;
        q_a.push_back(4'hD); q_b.push_back(4'hB);
        send_word(4'hD, 1'b1);
        check("t6_msb_first", 32'(bus_b.data_out), 32'hB);
        check("t6_lsb_first", 32'(bus_a.data_out), 32'hD);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        q_a.push_back(4'h4); q_b.push_back(4'h2);
        data_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check("t6_valid_stays", 32'(bus_a.data_valid), 32'h1);
        check("t6_new_word_a",  32'(bus_a.data_out),   32'h4);
        check("t6_new_word_b",  32'(bus_b.data_out),   32'h2);
        check("t6_ovr",         32'(bus_a.overrun),    32'h0);
        tick();
        check("t6_valid_drop",  32'(bus_a.data_valid), 32'h0);

        tick(); tick();
        check("end_queue_a", 32'(q_a.size()), 32'h0);
        check("end_queue_b", 32'(q_b.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel receive stage. Sits directly downstream of the right-shift PISO serializer and consumes its one-bit-per-clock stream (LSB first by default). It rebuilds N-bit words and presents each one on a registered parallel output with a valid/ready handshake. Frame alignment, gapped input strobes and overrun detection are handled inside the block.

Parameters:
N, 4, word width in bits (N >= 2)
LSB_FIRST, 1, 1 = first received bit lands in data_out[0] (matches the right-shift serializer); 0 = first received bit lands in data_out[N-1]

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  serial data bit; sampled only when shift_en=1
shift_en  input  1  bit strobe; 1 = serial_in carries a valid bit this cycle
frame_start  input  1  qualified by shift_en; marks the current bit as bit 0 of a new word
data_out  output  N  assembled word; holds its value while data_valid=1
data_valid  output  1  word available on data_out
data_ready  input  1  consumer accepts the word when data_valid & data_ready
overrun  output  1  sticky; a completed word was dropped because the output was still occupied
clr_overrun  input  1  clears overrun
bit_cnt  output  clog2(N)  bits collected in the current partial word (debug/status)

Behaviour:
- Reset (rst=1 at a clk edge) clears the following; rst has priority over every other input:
  - shift register, bit_cnt, data_out to 0
  - data_valid=0, overrun=0
  - FSM to IDLE
- FSM states:
  - IDLE: ignores bits until shift_en & frame_start. That bit is captured as bit 0, bit_cnt=1, next state COLLECT.
  - COLLECT: each cycle with shift_en=1 captures one bit and increments bit_cnt. shift_en=0 means hold; gaps of any length are legal.
- Shift rules:
  - LSB_FIRST=1: sr <= {serial_in, sr[N-1:1]}
  - LSB_FIRST=0: sr <= {sr[N-2:0], serial_in}
- Word completion: the edge that captures bit N-1 (bit_cnt == N-1 with shift_en=1) completes the word.
  - The completed word, including the bit captured on that edge, goes to the output stage.
  - bit_cnt returns to 0 and the FSM stays in COLLECT, so back-to-back words need no further frame_start.
- Latency: data_valid rises on the same edge that captures the last bit, one cycle after that bit is presented.
- Output stage (evaluated at the completion edge):
  - Output empty, or the held word is being accepted this cycle (data_valid & data_ready): load data_out, data_valid=1.
  - Output full and not being accepted: drop the new word, data_out is unchanged, overrun<=1.
  - Accept with no completion: data_valid<=0 on the next edge; data_out holds its value.
- overrun stays set until clr_overrun=1. If clr_overrun and a new overrun event occur in the same cycle, overrun stays 1.
- frame_start & shift_en while in COLLECT with bit_cnt != 0 (resync):
  - the partial word is discarded with no overrun
  - the current bit becomes bit 0 and bit_cnt=1
- frame_start & shift_en exactly at bit_cnt == 0 in COLLECT is a normal word start.
- frame_start without shift_en is ignored.
- data_out must not change while data_valid=1 and data_ready=0.
- Mid-word reset: the partial word is lost and the block requires a new frame_start.

Test Plan:
1. Reset, then N=4, LSB_FIRST=1, bits 1,1,0,1 on consecutive shift_en cycles (frame_start with the first), data_ready=1 -> data_valid is high for 1 cycle after bit 4 with data_out=4'b1011. Repeat with rst asserted mid-word -> all outputs 0 and IDLE.
2. Same word 4'hB sent with 0-3 idle cycles of shift_en=0 between bits -> data_out=4'hB, bit_cnt holds value during gaps.
3. data_ready=0, send 4'hA then 4'h5 -> data_out stays 4'hA, overrun=1 after the second word; pulse clr_overrun -> overrun=0; raise data_ready -> valid drops.
4. Continuous stream 4'h3,4'hC with data_ready=1, frame_start only on the first bit -> two valid pulses exactly 4 cycles apart, data_out 4'h3 then 4'hC, overrun=0.
5. Send bits 1,0 then frame_start with the bits of 4'h6 -> single word 4'h6, no overrun, no word from the partial bits.
6. LSB_FIRST=0 with bits 1,0,1,1 -> data_out=4'b1011; also a completion on the same cycle as an accept -> new word loaded, data_valid stays 1, no overrun.
